adc_scan_sequencer: RTL and testbench

- Controller that sequences the shared ADC converter across up to NUM_CH analog inputs (joystick/actuator feedback channels) in round-robin order.
- Per enabled channel: selects the mux, waits a settle time, issues a convert strobe, and collects 2^AVG_LOG2 samples.
- Emits one averaged result per channel to the AXI-lite counter/register bank.
- Sits between the AXI-lite register slave (enable/mask/start) and the ADC front-end.

---
 rtl/adc_scan_sequencer_if.sv | 27 ++
 rtl/adc_scan_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_adc_scan_sequencer.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_scan_sequencer_if.sv
// ADC front-end and averaged-result bus for adc_scan_sequencer.
// master: the sequencer (drives mux select, convert strobe and results).
// slave : the ADC front-end / result consumer side.
interface adc_scan_sequencer_if #(
  parameter int NUM_CH   = 4,
  parameter int ADC_BITS = 12
);
  localparam int CH_W = $clog2(NUM_CH);

  logic [CH_W-1:0]     adc_channel;
  logic                adc_convst;
  logic                adc_eoc;
  logic [ADC_BITS-1:0] adc_data;
  logic                result_valid;
  logic [CH_W-1:0]     result_ch;
  logic [ADC_BITS-1:0] result_data;

  modport master (
    output adc_channel, adc_convst, result_valid, result_ch, result_data,
    input  adc_eoc, adc_data
  );

  modport slave (
    input  adc_channel, adc_convst, result_valid, result_ch, result_data,
    output adc_eoc, adc_data
  );
endinterface

// File: rtl/adc_scan_sequencer.sv
// Round-robin ADC scan sequencer: settle, convert, average 2^AVG_LOG2
// samples per enabled channel, emit one result per channel.
// Optional threshold alarm per channel: define ADC_SCAN_THRESH_EN.
module adc_scan_sequencer #(
  parameter int NUM_CH         = 4,
  parameter int ADC_BITS       = 12,
  parameter int AVG_LOG2       = 2,
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                enable_i,
  input  logic                start_i,
  input  logic [NUM_CH-1:0]   ch_mask_i,
  input  logic                err_clear_i,
  output logic                busy_o,
  output logic                scan_done_o,
  output logic                timeout_err_o,
`ifdef ADC_SCAN_THRESH_EN
  input  logic [ADC_BITS-1:0] thresh_hi_i,
  output logic [NUM_CH-1:0]   alarm_o,
`endif
  adc_scan_sequencer_if.master bus
);

  localparam int CH_W    = $clog2(NUM_CH);
  localparam int ACC_W   = ADC_BITS + AVG_LOG2;
  localparam int SAMPLES = 1 << AVG_LOG2;
  localparam int CNT_W   = AVG_LOG2 + 1;
  localparam int TMR_MAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_CONVERT, S_WAIT_EOC, S_OUTPUT, S_NEXT
  } state_t;

  state_t            state_q, state_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic              terr_q;
  logic              tmo_set;
  logic              done;
  logic              nxt_found;
  logic [CH_W-1:0]   nxt_ch;
  logic [ADC_BITS-1:0] avg;

  // Lowest set bit of a mask (caller guarantees mask != 0).
  function automatic logic [CH_W-1:0] lowest(input logic [NUM_CH-1:0] m);
    logic [CH_W-1:0] r;
    r = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (m[i]) r = CH_W'(i);
    end
    return r;
  endfunction

  // Next set bit above the current channel in the latched mask.
  always_comb begin
    nxt_found = 1'b0;
    nxt_ch    = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask_q[i] && (i > int'(ch_q))) begin
        nxt_found = 1'b1;
        nxt_ch    = CH_W'(i);
      end
    end
  end

  // Truncating average: drop the AVG_LOG2 fractional bits of the sum.
  assign avg = acc_q[ACC_W-1:AVG_LOG2];

  // Next-state logic; the shared timer restarts on every state change so it
  // serves as both the settle counter and the end-of-conversion timeout.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    ch_d    = ch_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    tmr_d   = tmr_q + 1'b1;
    tmo_set = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        tmr_d = '0;
        if ((start_i || enable_i) && (|ch_mask_i)) begin
          mask_d  = ch_mask_i;
          ch_d    = lowest(ch_mask_i);
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (tmr_q == TMR_W'(SETTLE_CYCLES - 1)) state_d = S_CONVERT;
      end
      S_CONVERT: state_d = S_WAIT_EOC;
      S_WAIT_EOC: begin
        if (bus.adc_eoc) begin
          acc_d = acc_q + ACC_W'(bus.adc_data);
          if (cnt_q == CNT_W'(SAMPLES - 1)) begin
            state_d = S_OUTPUT;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = S_CONVERT;
          end
        end else if (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
          // Partial sum is thrown away in NEXT; no result for this channel.
          tmo_set = 1'b1;
          state_d = S_NEXT;
        end
      end
      S_OUTPUT: state_d = S_NEXT;
      S_NEXT: begin
        acc_d = '0;
        cnt_d = '0;
        if (nxt_found) begin
          ch_d    = nxt_ch;
          state_d = S_SETTLE;
        end else begin
          done = 1'b1;
          // Continuous mode re-samples the mask so edits apply per scan.
          if (enable_i && (|ch_mask_i)) begin
            mask_d  = ch_mask_i;
            ch_d    = lowest(ch_mask_i);
            state_d = S_SETTLE;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d != state_q) tmr_d = '0;
  end

  // State and datapath registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      mask_q  <= '0;
      ch_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      ch_q    <= ch_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
    end
  end

  // Sticky timeout flag; a fresh timeout beats a simultaneous clear.
  always_ff @(posedge clk_i) begin
    if (rst_i)            terr_q <= 1'b0;
    else if (tmo_set)     terr_q <= 1'b1;
    else if (err_clear_i) terr_q <= 1'b0;
  end

`ifdef ADC_SCAN_THRESH_EN
  logic [NUM_CH-1:0] alarm_q;

  // Per-channel over-threshold flag, refreshed only when that channel reports.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      alarm_q <= '0;
    end else if (state_q == S_OUTPUT) begin
      alarm_q[ch_q] <= (avg > thresh_hi_i);
    end
  end

  assign alarm_o = alarm_q;
`else
  // Threshold compare not built; results carry no alarm state.
`endif

  assign bus.adc_channel  = ch_q;
  assign bus.adc_convst   = (state_q == S_CONVERT);
  assign bus.result_valid = (state_q == S_OUTPUT);
  assign bus.result_ch    = ch_q;
  assign bus.result_data  = avg;
  assign busy_o           = (state_q != S_IDLE);
  assign scan_done_o      = done;
  assign timeout_err_o    = terr_q;

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Scoreboard bench for adc_scan_sequencer: an ADC model answers convert
// strobes with table values; expected averages are queued at stimulus time.
module tb_adc_scan_sequencer;

  localparam int NUM_CH  = 4;
  localparam int ADC_B   = 12;
  localparam int SETTLE  = 16;
  localparam int TMO     = 1024;
  localparam int EOC_DLY = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             enable;
  logic             start;
  logic [3:0]       ch_mask;
  logic             err_clear;
  logic             busy;
  logic             scan_done;
  logic             timeout_err;
`ifdef ADC_SCAN_THRESH_EN
  logic [ADC_B-1:0] thresh_hi;
  logic [3:0]       alarm;
`endif

  adc_scan_sequencer_if #(.NUM_CH(NUM_CH), .ADC_BITS(ADC_B)) bus ();

  adc_scan_sequencer #(
    .NUM_CH(NUM_CH), .ADC_BITS(ADC_B), .AVG_LOG2(2),
    .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .start_i(start),
    .ch_mask_i(ch_mask), .err_clear_i(err_clear), .busy_o(busy),
    .scan_done_o(scan_done), .timeout_err_o(timeout_err),
`ifdef ADC_SCAN_THRESH_EN
    .thresh_hi_i(thresh_hi), .alarm_o(alarm),
`endif
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct { logic [1:0] ch; logic [11:0] data; } exp_t;
  exp_t exp_q[$];

  logic [11:0] tbl [4][4];
  logic [3:0]  hold = 4'b0000;

  // ADC model: eoc EOC_DLY cycles after each convst; held channels never answer.
  int          pend = 0;
  logic [11:0] pval = '0;
  int          idx [4] = '{0, 0, 0, 0};
  int          convst_cnt = 0;
  always @(negedge clk) begin
    bus.adc_eoc = 1'b0;
    if (rst) begin
      pend = 0;
      for (int c = 0; c < 4; c++) idx[c] = 0;
    end else begin
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          bus.adc_eoc  = 1'b1;
          bus.adc_data = pval;
        end
      end
      if (bus.adc_convst) begin
        convst_cnt++;
        if (!hold[bus.adc_channel]) begin
          pend = EOC_DLY;
          pval = tbl[bus.adc_channel][idx[bus.adc_channel]];
          idx[bus.adc_channel] = (idx[bus.adc_channel] + 1) % 4;
        end
      end
    end
  end

  // Result monitor: every result must match the head of the scoreboard.
  always @(negedge clk) begin
    if (bus.result_valid) begin
      check("res_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("res_ch", bus.result_ch, e.ch);
        check("res_data", bus.result_data, e.data);
      end
    end
  end

  task automatic push_exp(input logic [3:0] m);
    for (int c = 0; c < 4; c++) begin
      if (m[c] && !hold[c]) begin
        int   sum;
        exp_t e;
        sum = 0;
        for (int k = 0; k < 4; k++) sum += int'(tbl[c][k]);
        e.ch   = 2'(c);
        e.data = 12'(sum / 4);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic start_scan(input logic [3:0] m);
    ch_mask = m;
    push_exp(m);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (!scan_done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, scan_done, 1);
  endtask

  task automatic set_ch(input int c, input logic [11:0] v);
    for (int k = 0; k < 4; k++) tbl[c][k] = v;
  endtask

  initial begin
    int   n;
    int   cs;
    logic stable;
    logic seen;
    logic bad;

    tbl[0] = '{12'h100, 12'h102, 12'h104, 12'h106};
    tbl[1] = '{12'h010, 12'h020, 12'h030, 12'h041};
    tbl[2] = '{12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF};
    tbl[3] = '{12'h7FF, 12'h800, 12'h800, 12'h800};
    rst = 1'b1; enable = 1'b0; start = 1'b0; ch_mask = '0; err_clear = 1'b0;
    bus.adc_eoc = 1'b0; bus.adc_data = '0;
`ifdef ADC_SCAN_THRESH_EN
    thresh_hi = 12'h800;
`endif
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_busy", busy, 0);
    check("rst_convst", bus.adc_convst, 0);
    check("rst_valid", bus.result_valid, 0);
    check("rst_done", scan_done, 0);
    check("rst_terr", timeout_err, 0);
    check("rst_chan", bus.adc_channel, 0);
`ifdef ADC_SCAN_THRESH_EN
    check("rst_alarm", alarm, 0);
`endif

    // Empty mask: no scan, no scan_done
    ch_mask = 4'b0000; start = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy || scan_done) bad = 1'b1;
    end
    check("mask0_idle", bad, 0);

    // Scan 0101: settle timing from start, then ch0 0x103 and ch2 0xFFF
    cs = convst_cnt;
    ch_mask = 4'b0101; push_exp(4'b0101); start = 1'b1;
    n = 0; stable = 1'b1; seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      start = 1'b0;
      n++;
      if (bus.adc_convst) seen = 1'b1;
      if (bus.adc_channel != 2'd0) stable = 1'b0;
    end
    check("settle_cycles", n, SETTLE + 1);
    check("settle_chan_stable", stable, 1);
    wait_done("scan0101_done", 200);
    @(negedge clk);
    check("scan0101_busy_after", busy, 0);
    check("scan0101_exp_empty", exp_q.size(), 0);
    check("scan0101_convst", convst_cnt - cs, 8);

    // Timeout on ch1: only ch0 reported, flag sticky until cleared
    hold = 4'b0010;
    start_scan(4'b0011);
    wait_done("tmo_done", 2000);
    @(negedge clk);
    check("tmo_busy_after", busy, 0);
    check("tmo_exp_empty", exp_q.size(), 0);
    repeat (5) @(negedge clk);
    check("tmo_sticky", timeout_err, 1);
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    check("tmo_cleared", timeout_err, 0);
    hold = 4'b0000;

    // Continuous scan with mask change mid-scan, then enable dropped
    enable = 1'b1; ch_mask = 4'b0011; push_exp(4'b0011);
    @(negedge clk);
    check("cont_busy", busy, 1);
    ch_mask = 4'b1000; push_exp(4'b1000);
    wait_done("cont_done1", 300);
    @(negedge clk);
    check("cont_restart", busy, 1);
    check("cont_restart_ch", bus.adc_channel, 3);
    enable = 1'b0;
    wait_done("cont_done2", 300);
    @(negedge clk);
    check("cont_idle", busy, 0);
    repeat (20) @(negedge clk);
    check("cont_stay_idle", busy, 0);
    check("cont_exp_empty", exp_q.size(), 0);

    // Reset during WAIT_EOC: abort silently, then scan normally
    ch_mask = 4'b0001; start = 1'b1;
    n = 0; seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      start = 1'b0;
      n++;
      if (bus.adc_convst) seen = 1'b1;
    end
    check("rstmid_convst_seen", seen, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_busy", busy, 0);
    check("rstmid_convst", bus.adc_convst, 0);
    check("rstmid_valid", bus.result_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy || scan_done || bus.result_valid) bad = 1'b1;
    end
    check("rstmid_quiet", bad, 0);
    start_scan(4'b0001);
    wait_done("rstmid_rescan_done", 200);
    @(negedge clk);
    check("rstmid_exp_empty", exp_q.size(), 0);

`ifdef ADC_SCAN_THRESH_EN
    // Threshold alarm set and cleared per channel
    set_ch(0, 12'h900);
    set_ch(1, 12'h100);
    start_scan(4'b0011);
    wait_done("thr_done1", 200);
    @(negedge clk);
    check("thr_alarm1", alarm, 4'b0001);
    set_ch(0, 12'h700);
    start_scan(4'b0001);
    wait_done("thr_done2", 200);
    @(negedge clk);
    check("thr_alarm2", alarm, 4'b0000);
    check("thr_exp_empty", exp_q.size(), 0);
`else
    set_ch(0, 12'h900);
    start_scan(4'b0001);
    wait_done("plain_done", 200);
    @(negedge clk);
    check("plain_exp_empty", exp_q.size(), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
